fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Fetch stage of the LC-3b pipeline, directly upstream of the decode stage.
//  Holds the PC, issues instruction-cache reads and loads the DE latches (de_npc, de_ir, de_v).
//  Applies the stall and branch-redirect rules from the downstream stages.
//  A one-entry skid buffer keeps a completed fetch when decode cannot accept it.
// PARAMETERS
//  RESET_PC  16'h0000  PC value after reset
//  PC_STEP   2         byte increment per sequential fetch
// PORTS
//  clk              in   1   pipeline clock, rising edge
//  rst              in   1   asynchronous reset, active-high
//  icache_addr      out  16  fetch address, always equal to the current PC
//  icache_r         in   1   icache_data valid for icache_addr this cycle
//  icache_data      in   16  instruction word
//  dep_stall        in   1   decode dependency stall
//  mem_stall        in   1   memory-stage stall (freezes DE and AGEX)
//  v_de_br_stall    in   1   valid control-flow instruction in DE
//  v_agex_br_stall  in   1   valid control-flow instruction in AGEX
//  v_mem_br_stall   in   1   valid control-flow instruction in MEM
//  mem_pcmux        in   2   0: no redirect, 1: target_pc, 2: trap_pc, 3: reserved (no redirect)
//  target_pc        in   16  branch/jump target from MEM
//  trap_pc          in   16  trap vector target from MEM
//  de_npc           out  16  PC+PC_STEP of the instruction in DE
//  de_ir            out  16  instruction in DE
//  de_v             out  1   DE latch valid
// BEHAVIOUR
//  - Reset (async, any time): PC=RESET_PC, de_npc=0, de_ir=0, de_v=0, skid empty, state FETCH.
//  - Derived signals:
//      ld_de    = ~(dep_stall | mem_stall)
//      br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall
//      redirect = v_mem_br_stall & ~mem_stall & (mem_pcmux==1 | mem_pcmux==2)
//      fire     = state FETCH & icache_r & ~br_stall & ~redirect
//  - Priority at each rising edge: rst > redirect > HOLD drain > fire > idle.
//  - Redirect:
//      PC <= target_pc (pcmux 1) or trap_pc (pcmux 2).
//      Skid is cleared; state -> FETCH; icache_data that cycle is discarded.
//      If ld_de: de_v <= 0.
//  - State FETCH (skid empty):
//      fire & ld_de:  de_npc <= PC+PC_STEP, de_ir <= icache_data, de_v <= 1, PC <= PC+PC_STEP.
//      fire & ~ld_de: skid <= {PC+PC_STEP, icache_data}, PC <= PC+PC_STEP, DE holds, state -> HOLD.
//      ~fire & ld_de: de_v <= 0 (bubble); de_npc/de_ir may update but are don't-care.
//      ~fire & ~ld_de: DE and PC hold.
//  - State HOLD (skid full):
//      No fetch is accepted; icache_r is ignored and PC holds.
//      If ld_de: DE <= skid with de_v <= 1, skid emptied, state -> FETCH.
//      The next fetch can fire on the following cycle at the earliest.
//  - Latency: icache_r at cycle N with no stalls -> de_v=1 and de_ir valid after edge N+1.
//  - PC arithmetic is 16-bit modulo: 16'hFFFE + 2 wraps to 16'h0000 with no flag.
//  - Branches:
//      br_stall blocks new fetches until MEM resolves.
//      A not-taken branch (mem_pcmux=0) frees fetch at the current PC once v_mem_br_stall drops.
//  - dep_stall together with br_stall: DE holds and no fetch occurs.
//  - mem_stall suppresses redirect; the redirect is taken on the first cycle mem_stall is low.
//  - Outputs de_npc, de_ir and de_v are registered only; icache_addr is combinational from PC.
// TESTING
//  1. Sequential fetch: reset, icache_r=1, no stalls, data 16'h1234 then 16'h5678
//     -> edge1: de_ir=1234, de_npc=0002, de_v=1; edge2: de_ir=5678, de_npc=0004; icache_addr 0,2,4.
//  2. Cache miss: icache_r=0 for 3 cycles at PC=0004 -> PC holds 0004, de_v=0 for 3 cycles,
//     then normal fetch resumes.
//  3. Skid: dep_stall=1 for 2 cycles while icache_r=1 at PC=0004 -> PC=0006, state HOLD, DE unchanged;
//     dep_stall drops -> de_npc=0006, de_v=1; the next fetch is at 0006.
//  4. Branch: v_de_br_stall=1 -> PC frozen, de_v=0 bubbles; then v_mem_br_stall=1, mem_pcmux=1,
//     target_pc=0040 -> PC=0040; the first de_ir from 0040 appears one edge after icache_r.
//  5. Trap redirect with icache_r=1 the same cycle: mem_pcmux=2, trap_pc=0200
//     -> PC=0200, fetched word discarded, de_v=0; with mem_stall=1 the redirect is deferred.
//  6. Reset asserted mid-HOLD, between clock edges -> de_v=0, PC=RESET_PC and skid empty immediately;
//     also check wrap: PC=FFFE fetch -> de_npc=0000.

Source files
------------

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: PC register, icache request, DE latches and a one-entry
// skid buffer that keeps a completed fetch while decode is stalled.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] icache_addr,
  input  logic        icache_r,
  input  logic [15:0] icache_data,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] de_npc_q, de_npc_d;
  logic [15:0] de_ir_q, de_ir_d;
  logic        de_v_q, de_v_d;
  logic [15:0] skid_npc_q, skid_npc_d;
  logic [15:0] skid_ir_q, skid_ir_d;

  logic        ld_de, br_stall, redirect, fire;
  logic [15:0] pc_inc;

  assign ld_de    = ~(dep_stall | mem_stall);
  assign br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
  assign redirect = v_mem_br_stall & ~mem_stall &
                    ((mem_pcmux == 2'd1) | (mem_pcmux == 2'd2));
  assign fire     = (state_q == FETCH) & icache_r & ~br_stall & ~redirect;
  assign pc_inc   = pc_q + PC_STEP;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    de_npc_d   = de_npc_q;
    de_ir_d    = de_ir_q;
    de_v_d     = de_v_q;
    skid_npc_d = skid_npc_q;
    skid_ir_d  = skid_ir_q;

    if (redirect) begin
      pc_d       = (mem_pcmux == 2'd1) ? target_pc : trap_pc;
      state_d    = FETCH;
      skid_npc_d = '0;
      skid_ir_d  = '0;
      if (ld_de) de_v_d = 1'b0;
    end else if (state_q == HOLD) begin
      // Drain takes the whole cycle; a new fetch waits for the next one.
      if (ld_de) begin
        de_npc_d = skid_npc_q;
        de_ir_d  = skid_ir_q;
        de_v_d   = 1'b1;
        state_d  = FETCH;
      end
    end else if (fire) begin
      pc_d = pc_inc;
      if (ld_de) begin
        de_npc_d = pc_inc;
        de_ir_d  = icache_data;
        de_v_d   = 1'b1;
      end else begin
        skid_npc_d = pc_inc;
        skid_ir_d  = icache_data;
        state_d    = HOLD;
      end
    end else if (ld_de) begin
      de_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      de_npc_q   <= '0;
      de_ir_q    <= '0;
      de_v_q     <= 1'b0;
      skid_npc_q <= '0;
      skid_ir_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      de_npc_q   <= de_npc_d;
      de_ir_q    <= de_ir_d;
      de_v_q     <= de_v_d;
      skid_npc_q <= skid_npc_d;
      skid_ir_q  <= skid_ir_d;
    end
  end

  assign icache_addr = pc_q;
  assign de_npc      = de_npc_q;
  assign de_ir       = de_ir_q;
  assign de_v        = de_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected {de_npc, de_ir}
// words; a monitor pops one each time DE loads a valid instruction.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] icache_addr;
  logic        icache_r;
  logic [15:0] icache_data;
  logic        dep_stall, mem_stall;
  logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc, trap_pc;
  logic [15:0] de_npc, de_ir;
  logic        de_v;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk(clk), .rst(rst), .icache_addr(icache_addr), .icache_r(icache_r),
    .icache_data(icache_data), .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux),
    .target_pc(target_pc), .trap_pc(trap_pc),
    .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: DE carries a new instruction when it was loadable at the edge.
  initial begin
    logic ld_at_edge;
    logic [31:0] exp;
    forever begin
      @(posedge clk);
      ld_at_edge = ~(dep_stall | mem_stall) & ~rst;
      @(negedge clk);
      if (!rst && de_v && ld_at_edge) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL de_out: unexpected npc=%h ir=%h, queue empty", de_npc, de_ir);
        end else begin
          exp = exp_q.pop_front();
          if ({de_npc, de_ir} === exp) passed++;
          else $display("FAIL de_out: got npc=%h ir=%h expected npc=%h ir=%h",
                        de_npc, de_ir, exp[31:16], exp[15:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; icache_r = 1'b0; icache_data = '0; dep_stall = 1'b0; mem_stall = 1'b0;
    v_de_br_stall = 1'b0; v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b0;
    mem_pcmux = 2'd0; target_pc = '0; trap_pc = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_addr", icache_addr, 16'h0000);
    check("rst_de_v", {15'd0, de_v}, 16'h0000);
    check("rst_de_ir", de_ir, 16'h0000);
    check("rst_de_npc", de_npc, 16'h0000);
    rst = 1'b0;

    // Sequential fetch
    icache_r = 1'b1; icache_data = 16'h1234; exp_q.push_back({16'h0002, 16'h1234});
    tick(); check("seq_addr1", icache_addr, 16'h0002);
    icache_data = 16'h5678; exp_q.push_back({16'h0004, 16'h5678});
    tick(); check("seq_addr2", icache_addr, 16'h0004);

    // Cache miss: PC holds, bubbles
    icache_r = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("miss_addr", icache_addr, 16'h0004);
      check("miss_de_v", {15'd0, de_v}, 16'h0000);
    end
    icache_r = 1'b1; icache_data = 16'h9ABC; exp_q.push_back({16'h0006, 16'h9ABC});
    tick(); check("resume_addr", icache_addr, 16'h0006);

    // Skid: fetch completes under dep_stall
    dep_stall = 1'b1; icache_data = 16'hAAAA;
    tick();
    check("skid_addr", icache_addr, 16'h0008);
    check("skid_de_ir_hold", de_ir, 16'h9ABC);
    check("skid_de_v_hold", {15'd0, de_v}, 16'h0001);
    icache_data = 16'hBBBB;
    tick(); check("hold_addr", icache_addr, 16'h0008);
    dep_stall = 1'b0; icache_data = 16'hCCCC; exp_q.push_back({16'h0008, 16'hAAAA});
    tick(); check("drain_addr", icache_addr, 16'h0008);
    exp_q.push_back({16'h000A, 16'hCCCC});
    tick(); check("post_drain_addr", icache_addr, 16'h000A);

    // Branch stall then taken redirect
    icache_data = 16'hDEAD; v_de_br_stall = 1'b1;
    repeat (2) begin
      tick();
      check("brst_addr", icache_addr, 16'h000A);
      check("brst_de_v", {15'd0, de_v}, 16'h0000);
    end
    v_de_br_stall = 1'b0; v_mem_br_stall = 1'b1; mem_pcmux = 2'd1; target_pc = 16'h0040;
    tick();
    check("br_target", icache_addr, 16'h0040);
    check("br_de_v", {15'd0, de_v}, 16'h0000);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0; icache_data = 16'h1111;
    exp_q.push_back({16'h0042, 16'h1111});
    tick(); check("br_next", icache_addr, 16'h0042);

    // Not-taken branch
    v_mem_br_stall = 1'b1; icache_data = 16'hDEAD;
    tick(); check("nt_addr", icache_addr, 16'h0042);
    v_mem_br_stall = 1'b0; icache_data = 16'h2222; exp_q.push_back({16'h0044, 16'h2222});
    tick(); check("nt_next", icache_addr, 16'h0044);

    // Trap redirect deferred by mem_stall, then taken
    v_mem_br_stall = 1'b1; mem_pcmux = 2'd2; trap_pc = 16'h0200; mem_stall = 1'b1;
    icache_data = 16'hBAD0;
    tick();
    check("trap_defer_addr", icache_addr, 16'h0044);
    check("trap_defer_de_v", {15'd0, de_v}, 16'h0001);
    mem_stall = 1'b0;
    tick();
    check("trap_addr", icache_addr, 16'h0200);
    check("trap_de_v", {15'd0, de_v}, 16'h0000);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0; icache_data = 16'h3333;
    exp_q.push_back({16'h0202, 16'h3333});
    tick(); check("trap_next", icache_addr, 16'h0202);

    // Reserved pcmux: no redirect, fetch still blocked
    v_mem_br_stall = 1'b1; mem_pcmux = 2'd3; target_pc = 16'h0040; trap_pc = 16'h0300;
    tick(); check("pcmux3_addr", icache_addr, 16'h0202);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0;

    // Async reset in the middle of HOLD
    dep_stall = 1'b1; icache_data = 16'h4444;
    tick(); check("hold2_addr", icache_addr, 16'h0204);
    #1 rst = 1'b1;
    #1;
    check("arst_addr", icache_addr, 16'h0000);
    check("arst_de_v", {15'd0, de_v}, 16'h0000);
    #1 rst = 1'b0;
    dep_stall = 1'b0; icache_data = 16'h5555; exp_q.push_back({16'h0002, 16'h5555});
    tick(); check("arst_next", icache_addr, 16'h0002);

    // PC wrap
    icache_r = 1'b0; v_mem_br_stall = 1'b1; mem_pcmux = 2'd1; target_pc = 16'hFFFE;
    tick(); check("wrap_pc", icache_addr, 16'hFFFE);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0; icache_r = 1'b1; icache_data = 16'h7777;
    exp_q.push_back({16'h0000, 16'h7777});
    tick(); check("wrap_addr", icache_addr, 16'h0000);

    icache_r = 1'b0;
    repeat (2) tick();
    check("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
